// File: rtl/cordic_dac_tx.sv
// cordic_dac_tx
// Buffers CORDIC (x, y) result pairs in a small FIFO and serialises them to a
// dual-channel SPI-style DAC as 16-bit frames, MSB first:
//   [15:14] channel (00 = A/x, 01 = B/y), [13:12] = 00, [11:0] offset-binary.
// Optional macro CORDIC_DAC_SIN_CHANNEL_EN: when defined, y is stored too and
// every pair produces an A frame followed by a B frame. When undefined, only
// x is stored and sent.
//
// Parameters: width (sample bits), DEPTH (FIFO entries, power of two >= 2),
//             DIV (clocks per dac_sclk half-period, >= 1).
// Ports:
//   clock, resetn      : clock, async active-low reset
//   in_valid,x_in,y_in : pair input, accepted when in_ready=1
//   in_ready           : FIFO not full (0 during reset, 1 from first edge)
//   dac_cs_n,dac_sclk,dac_din : DAC serial interface (sclk idles low)
//   overflow           : sticky, a pair was offered while in_ready=0
//   busy               : FIFO non-empty or FSM not idle
module cordic_dac_tx #(
   parameter int width = 12,
   parameter int DEPTH = 4,
   parameter int DIV   = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             in_valid,
   input  logic [width-1:0] x_in,
   input  logic [width-1:0] y_in,
   output logic             in_ready,
   output logic             dac_cs_n,
   output logic             dac_sclk,
   output logic             dac_din,
   output logic             overflow,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(2 * DIV) + 1;
   localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [TW-1:0]    T_HI     = TW'(DIV - 1);      // last low-phase clock
   localparam logic [TW-1:0]    T_END    = TW'(2 * DIV - 1);  // last high-phase clock
   // GAP lasts 2*DIV-1 clocks; the following LOAD clock also keeps cs_n high,
   // so cs_n is high for exactly 2*DIV clocks between the A and B frames.
   localparam logic [TW-1:0]    T_GAP    = TW'(2 * DIV - 2);
   localparam logic [width-1:0] MSB      = width'(1) << (width - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
   state_t state, state_nx;

   logic [width-1:0] x_mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             rdy_en;
   logic             push, pop;
   logic [TW-1:0]    tick;
   logic [3:0]       bitn;
   logic [15:0]      sreg;
   logic             chan;
   logic [width-1:0] src, ob;
   logic [11:0]      data12;
   logic [15:0]      frame;

`ifdef CORDIC_DAC_SIN_CHANNEL_EN
   logic [width-1:0] y_mem [DEPTH];
   logic [width-1:0] y_hold;  // y of the pair whose A frame is in flight
`else
   logic unused_y;
   assign unused_y = ^y_in;
   assign chan     = 1'b0;
`endif

   // rdy_en keeps in_ready low until the first edge after reset release
   assign in_ready = rdy_en && (count != FULL_CNT);
   assign push     = in_valid && in_ready;
   assign pop      = (state == LOAD) && !chan;  // one pop per pair, at its A frame
   assign busy     = (state != IDLE) || (count != '0);
   assign dac_din  = sreg[15];                 // sreg drains to zero by frame end

   // frame assembly: MSB invert gives offset binary, then left-align to 12 bits
   always_comb begin
      src = x_mem[rd_ptr];
`ifdef CORDIC_DAC_SIN_CHANNEL_EN
      if (chan) src = y_hold;
`endif
      ob     = src ^ MSB;
      data12 = 12'({ob, 12'b0} >> width);
      frame  = {1'b0, chan, 2'b00, data12};
   end

   always_ff @(posedge clock) begin
      if (push) begin
         x_mem[wr_ptr] <= x_in;
`ifdef CORDIC_DAC_SIN_CHANNEL_EN
         y_mem[wr_ptr] <= y_in;
`endif
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (count != '0) state_nx = LOAD;
         LOAD:    state_nx = SHIFT;
         SHIFT:   if (tick == T_END && bitn == 4'd0) state_nx = GAP;
         GAP: begin
            if (tick == T_GAP) begin
`ifdef CORDIC_DAC_SIN_CHANNEL_EN
               state_nx = chan ? IDLE : LOAD;
`else
               state_nx = IDLE;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rdy_en   <= 1'b0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         tick     <= '0;
         bitn     <= '0;
         sreg     <= '0;
         dac_cs_n <= 1'b1;
         dac_sclk <= 1'b0;
`ifdef CORDIC_DAC_SIN_CHANNEL_EN
         chan     <= 1'b0;
         y_hold   <= '0;
`endif
      end else begin
         rdy_en <= 1'b1;
         if (in_valid && !in_ready) overflow <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;  // wraps modulo DEPTH
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         case (state)
            LOAD: begin
               sreg     <= frame;
               dac_cs_n <= 1'b0;
               dac_sclk <= 1'b0;
               tick     <= '0;
               bitn     <= 4'd15;
`ifdef CORDIC_DAC_SIN_CHANNEL_EN
               if (!chan) y_hold <= y_mem[rd_ptr];
`endif
            end
            SHIFT: begin
               tick <= tick + 1'b1;
               if (tick == T_HI) dac_sclk <= 1'b1;
               // data moves only on the falling sclk edge
               if (tick == T_END) begin
                  tick     <= '0;
                  dac_sclk <= 1'b0;
                  sreg     <= sreg << 1;
                  bitn     <= bitn - 1'b1;
                  if (bitn == 4'd0) dac_cs_n <= 1'b1;
               end
            end
            GAP: begin
               tick <= tick + 1'b1;
               if (tick == T_GAP) begin
                  tick <= '0;
`ifdef CORDIC_DAC_SIN_CHANNEL_EN
                  chan <= ~chan;
`endif
               end
            end
            default: tick <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_dac_tx.sv
// Bench for cordic_dac_tx: directed pairs, a scoreboard of expected DAC words
// derived from the sample values, a bus decoder, and per-cycle checks of
// in_ready/overflow/busy against a FIFO-occupancy model.
module tb_cordic_dac_tx;
   localparam int W = 12, DEPTH = 4, DIV = 4;
`ifdef CORDIC_DAC_SIN_CHANNEL_EN
   localparam int NF = 2;
`else
   localparam int NF = 1;
`endif

   logic clock = 1'b0, resetn = 1'b1, in_valid = 1'b0;
   logic [W-1:0] x_in = '0, y_in = '0;
   logic in_ready, dac_cs_n, dac_sclk, dac_din, overflow, busy;

   int errors = 0, checks = 0;

   cordic_dac_tx #(.width(W), .DEPTH(DEPTH), .DIV(DIV)) dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
      .in_ready(in_ready), .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din),
      .overflow(overflow), .busy(busy));

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // DAC word for one sample: signed value shifted into 0..2^W-1, left-aligned
   function automatic int model_word(input int ch, input logic [W-1:0] s);
      int v;
      v = int'($signed(s)) + (1 << (W - 1));
      return (ch << 14) | (v << (12 - W));
   endfunction

   // ---------------- model / monitor state ----------------
   int  exp_q[$];
   int  rx_log[$];
   int  m_cnt = 0, post_edges = 0, frames_started = 0;
   int  high_len = 0, low_len = 0, bits = 0, interpair = 0;
   bit  pend_push = 0, pend_ovf = 0, m_ovf = 0, in_frame = 0;
   bit  prev_cs = 1, prev_sclk = 0, prev_din = 0;
   logic [15:0] word = '0;

   initial forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) post_edges = 0;
      else post_edges++;
   end

   initial forever begin
      @(negedge clock);
      if (!resetn) begin
         exp_q.delete();
         m_cnt = 0; pend_push = 0; pend_ovf = 0; m_ovf = 0; in_frame = 0;
         prev_cs = 1; prev_sclk = 0; prev_din = 0; frames_started = 0; high_len = 0;
      end else begin
         bit exp_rdy, is_a;
         if (pend_push) m_cnt++;
         if (pend_ovf)  m_ovf = 1;
         pend_push = 0; pend_ovf = 0;
         // frame start: a channel-A start means the pair left the FIFO
         if (prev_cs && !dac_cs_n) begin
            is_a = (NF == 1) || (frames_started % 2 == 0);
            if (is_a) begin
               chk("pop_nonempty", int'(m_cnt > 0), 1);
               if (m_cnt > 0) m_cnt--;
               if (frames_started > 0 && (interpair == 0 || high_len < interpair))
                  interpair = high_len;
            end else begin
               chk("ab_gap", high_len, 2 * DIV);
            end
            frames_started++;
            in_frame = 1; bits = 0; low_len = 0; word = '0;
         end
         // frame end
         if (!prev_cs && dac_cs_n && in_frame) begin
            chk("frame_bits", bits, 16);
            chk("frame_cs_low", low_len, 32 * DIV);
            chk("busy_in_gap", busy, 1);
            if (exp_q.size() == 0) chk("frame_expected", 0, 1);
            else chk("frame_word", int'(word), exp_q.pop_front());
            rx_log.push_back(int'(word));
            in_frame = 0; high_len = 0;
         end
         if (!dac_cs_n) begin
            low_len++;
            if (!prev_sclk && dac_sclk) begin
               word = {word[14:0], dac_din};
               bits++;
            end
            if (prev_sclk && dac_sclk) chk("din_hold", dac_din, prev_din);
         end else begin
            chk("sclk_idle", dac_sclk, 0);
            high_len++;
         end
         exp_rdy = (post_edges > 0) && (m_cnt != DEPTH);
         chk("in_ready", in_ready, exp_rdy);
         chk("overflow", overflow, m_ovf);
         if (m_cnt > 0 || !dac_cs_n) chk("busy", busy, 1);
         // inputs seen now are sampled at the next rising edge
         if (in_valid) begin
            if (exp_rdy) begin
               pend_push = 1;
               exp_q.push_back(model_word(0, x_in));
               if (NF == 2) exp_q.push_back(model_word(1, y_in));
            end else begin
               pend_ovf = 1;
            end
         end
         prev_cs = dac_cs_n; prev_sclk = dac_sclk; prev_din = dac_din;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_pair(input logic [W-1:0] x, input logic [W-1:0] y);
      in_valid = 1; x_in = x; y_in = y;
      @(posedge clock); #1;
      in_valid = 0;
   endtask

   task automatic wait_idle(input string name, input int max);
      int i;
      for (i = 0; i < max; i++) begin
         @(posedge clock); #1;
         if (!busy && dac_cs_n) break;
      end
      chk(name, int'(i < max), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lit_a[3], lit_b[3], base, k, rises, n;
      bit prev;
      lit_a = '{16'h0800, 16'h0FFF, 16'h0000};
      lit_b = '{16'h4000, 16'h47FF, 16'h4FFF};

      // reset state
      #2 resetn = 0;
      #1;
      chk("rst_cs_n", dac_cs_n, 1);
      chk("rst_sclk", dac_sclk, 0);
      chk("rst_din", dac_din, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clock);
      #1 resetn = 1;
      chk("ready_before_edge", in_ready, 0);
      @(posedge clock); #1;
      chk("ready_after_edge", in_ready, 1);

      // x=0, y=-2048: latency and frame contents
      push_pair(12'h000, 12'h800);
      chk("cs_high_at_push", dac_cs_n, 1);
      for (k = 1; k <= 8; k++) begin
         @(posedge clock); #1;
         if (!dac_cs_n) break;
      end
      chk("latency", k, 2);
      wait_idle("idle_pair1", 3000);
      // full-scale positive and negative samples
      push_pair(12'h7FF, 12'hFFF);
      wait_idle("idle_pair2", 3000);
      push_pair(12'h800, 12'h7FF);
      wait_idle("idle_pair3", 3000);
      chk("rx_count_3pairs", rx_log.size(), 3 * NF);
      for (int i = 0; i < 3; i++) begin
         chk("lit_a", rx_log[i * NF], lit_a[i]);
         if (NF == 2) chk("lit_b", rx_log[i * NF + 1], lit_b[i]);
      end

      // overflow: in_valid held for 6 clocks
      base = rx_log.size();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1; x_in = W'(37 * i + 5); y_in = W'(-11 * i - 1);
         @(posedge clock); #1;
      end
      in_valid = 0;
      chk("ovf_flag", overflow, 1);
      chk("ovf_not_ready", in_ready, 0);
      wait_idle("idle_ovf", 6000);
      chk("ovf_sent", rx_log.size() - base, 5 * NF);

      // push coinciding with a pop while 3 entries are queued
      base = rx_log.size();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; x_in = W'(100 * i + 7); y_in = W'(-50 * i - 3);
         @(posedge clock); #1;
      end
      in_valid = 0;
      chk("three_queued_ready", in_ready, 1);
      rises = 0; prev = dac_cs_n;
      for (n = 0; n < 3000; n++) begin
         @(posedge clock); #1;
         if (!prev && dac_cs_n) rises++;
         prev = dac_cs_n;
         if (rises == NF) break;
      end
      chk("first_pair_done", int'(rises == NF), 1);
      chk("interpair_known", int'(interpair > 1), 1);
      if (interpair > 1) begin
         repeat (interpair - 1) @(posedge clock);
         #1 in_valid = 1; x_in = 12'h123; y_in = 12'hABC;
         @(posedge clock); #1;
         in_valid = 0;
         chk("pop_same_edge", dac_cs_n, 0);
         chk("push_pop_ready", in_ready, 1);
         push_pair(12'h456, 12'h789);
         chk("fourth_fills", in_ready, 0);
      end
      wait_idle("idle_pushpop", 6000);
      chk("pushpop_sent", rx_log.size() - base, 6 * NF);

      // reset in the middle of SHIFT
      push_pair(12'h555, 12'h2AA);
      for (k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         if (!dac_cs_n) break;
      end
      chk("mid_frame_started", int'(k < 20), 1);
      repeat (40) @(posedge clock);
      #3 resetn = 0;
      #1;
      chk("abort_cs_n", dac_cs_n, 1);
      chk("abort_sclk", dac_sclk, 0);
      chk("abort_busy", busy, 0);
      chk("abort_din", dac_din, 0);
      chk("abort_overflow", overflow, 0);
      chk("abort_in_ready", in_ready, 0);
      base = rx_log.size();
      repeat (2) @(posedge clock);
      #1 resetn = 1;
      chk("ready_before_edge2", in_ready, 0);
      @(posedge clock); #1;
      chk("ready_after_edge2", in_ready, 1);
      push_pair(12'hFFF, 12'h001);
      wait_idle("idle_after_abort", 3000);
      chk("after_abort_count", rx_log.size() - base, NF);
      chk("after_abort_a", rx_log[base], 16'h07FF);
      if (NF == 2) chk("after_abort_b", rx_log[base + 1], 16'h4801);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cordic_dac_tx.md
CORDIC_DAC_TX -- requirements
Module: cordic_dac_tx

Interface
REQ-001 SHALL have parameter width, default 12: sample width of x/y inputs, two's complement.
REQ-002 SHALL have parameter DEPTH, default 4: sample-pair FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter DIV, default 4: system clocks per dac_sclk half-period; at least 1.
REQ-004 SHALL have port clock  input  1  sole clock; all flops on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  a CORDIC result pair is present on x_in/y_in.
REQ-007 SHALL have port x_in  input  width  cosine result, signed.
REQ-008 SHALL have port y_in  input  width  sine result, signed.
REQ-009 SHALL have port in_ready  output  1  the FIFO is not full.
REQ-010 SHALL have port dac_cs_n  output  1  DAC frame select, active low.
REQ-011 SHALL have port dac_sclk  output  1  DAC serial clock; idles low.
REQ-012 SHALL have port dac_din  output  1  DAC serial data, MSB first.
REQ-013 SHALL have port overflow  output  1  sticky flag: a sample was dropped.
REQ-014 SHALL have port busy  output  1  the FIFO is non-empty or a frame is in progress.

Function
REQ-015 The block SHALL accept a pair into the FIFO on a clock where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 0 exactly when the FIFO holds DEPTH entries; there is no push-through when full, even on a clock where an entry is popped.
REQ-017 If in_valid=1 while in_ready=0, the block SHALL drop the pair and set overflow to 1; overflow stays 1 until reset.
REQ-018 Each sample SHALL be converted to offset binary by inverting its MSB (for example, -2048 -> 0, 0 -> 2048, 2047 -> 4095).
REQ-019 A frame SHALL be 16 bits: [15:14] channel (00 = x/A, 01 = y/B), [13:12] = 00, [11:0] = offset-binary data; for width < 12, data is left-aligned and zero-padded.
REQ-020 The FSM SHALL have states IDLE, LOAD, SHIFT and GAP.
REQ-021 IDLE -> LOAD when the FIFO is non-empty; the FIFO pops in LOAD.
REQ-022 LOAD (1 clock) SHALL build the frame shift register and drive dac_cs_n low, then go to SHIFT.
REQ-023 SHIFT SHALL present each bit on dac_din for 2*DIV clocks: dac_sclk low for DIV clocks, then high for DIV clocks.
REQ-024 dac_din SHALL change only while dac_sclk is low (DAC samples on the rising edge).
REQ-025 After bit 0's high phase, SHIFT -> GAP; dac_sclk returns low and dac_cs_n goes high.
REQ-026 GAP SHALL hold dac_cs_n high for 2*DIV clocks.
REQ-027 GAP -> LOAD for the next channel of the same pair, or IDLE -> LOAD for a new pair.
REQ-028 Latency: a pair pushed into an empty FIFO while the FSM is in IDLE SHALL produce dac_cs_n low exactly 2 clocks after the push edge.
REQ-029 One frame SHALL occupy 1 + 32*DIV clocks from LOAD to the end of SHIFT.
REQ-030 A push and a pop in the same clock SHALL leave the FIFO count unchanged.
REQ-031 The FIFO pointers SHALL wrap modulo DEPTH.
REQ-032 busy SHALL be 0 only in IDLE with the FIFO empty.

Reset
REQ-033 While resetn=0, the block SHALL hold dac_cs_n=1, dac_sclk=0, dac_din=0, overflow=0, busy=0, in_ready=0, FIFO empty and state IDLE, asynchronously.
REQ-034 A reset asserted mid-frame SHALL abort the frame immediately with no partial completion; the FIFO contents are lost.
REQ-035 in_ready SHALL go to 1 on the first clock edge after resetn deasserts.

Configuration
REQ-036 With macro CORDIC_DAC_SIN_CHANNEL_EN defined, each pair SHALL produce two frames: channel A (x), then channel B (y), separated by one GAP.
REQ-037 Without CORDIC_DAC_SIN_CHANNEL_EN, each pair SHALL produce only the channel A frame, and y_in SHALL be ignored with no FIFO storage for it.

Verification
REQ-038 Reset mid-SHIFT -> dac_cs_n=1, dac_sclk=0 and busy=0 within the same cycle; the next pair transmits a complete frame.
REQ-039 DIV=4, macro defined, push x=0, y=-2048 -> frame A = 0x0800, then frame B = 0x4000; dac_cs_n low 2 clocks after the push; each frame 129 clocks; 8-clock gap between frames.
REQ-040 Macro undefined, push x=2047 -> one frame 0x0FFF and no channel B frame; busy drops to 0 after the GAP.
REQ-041 DEPTH=4, hold in_valid for 6 clocks while the FSM is stalled in the first frame -> 1 pair in flight, 4 queued, 1 dropped; overflow=1 and in_ready=0; all 5 accepted pairs are transmitted in order.
REQ-042 Push on the same clock as a pop with 3 entries queued -> count stays at 3; in_ready stays 1.
